// File: rtl/traffic_light_pkg.sv
// Shared traffic-light definitions: light codes, monitor state type and the
// legal-successor helpers. Used by the light controller and by the monitor.
package traffic_light_pkg;

    localparam logic [2:0] RED     = 3'b000;
    localparam logic [2:0] YELLOW  = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    // Never equal to a legal code, so it can stand for "no successor".
    localparam logic [2:0] NO_CODE = 3'b111;

    typedef enum logic {
        S_SYNC = 1'b0,
        S_RUN  = 1'b1
    } tsm_state_e;

    function automatic logic is_legal(input logic [2:0] code);
        return (code == RED) || (code == YELLOW) || (code == GREEN);
    endfunction

    function automatic logic [2:0] next_phase(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            RED:     nxt = YELLOW;
            YELLOW:  nxt = GREEN;
            GREEN:   nxt = RED;
            default: nxt = NO_CODE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tsm_dwell_counter.sv
// Saturating dwell counter: load1_i restarts the count at 1, inc_i adds one
// and sticks at the all-ones value, otherwise the count holds.
module tsm_dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load1_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: restart, saturating increment or hold.
    always_comb begin
        count_d = count_q;
        if (load1_i) begin
            count_d = CNT_ONE;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_signal_monitor.sv
// Passive monitor of the 3-bit traffic-light bus. Tracks the phase and its
// dwell, flags illegal codes, bad successors and dwell-window violations, and
// counts clean RED->YELLOW->GREEN->RED cycles.
// Build option: define TSM_STICKY_ERR_EN to make the err_* flags latch until
// err_clr; otherwise they are single-cycle pulses and err_clr is ignored.
module traffic_signal_monitor
    import traffic_light_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int RED_MIN = 20,
    parameter int RED_MAX = 24,
    parameter int YEL_MIN = 5,
    parameter int YEL_MAX = 8,
    parameter int GRN_MIN = 20,
    parameter int GRN_MAX = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       signal,
    input  logic             err_clr,
    output logic             synced,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic             err_seq,
    output logic             err_time,
    output logic             err_illegal,
    output logic             cycle_done,
    output logic [15:0]      cycle_cnt
);

    tsm_state_e       state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic             synced_q, synced_d;
    logic             err_seq_q, err_seq_d;
    logic             err_time_q, err_time_d;
    logic             err_illegal_q, err_illegal_d;
    logic             cycle_done_q, cycle_done_d;
    logic [15:0]      cycle_cnt_q, cycle_cnt_d;
    // Nothing has gone wrong since the current cycle's RED was entered.
    logic             cycle_ok_q, cycle_ok_d;

    logic [CNT_W-1:0] dwell_s;
    logic [CNT_W-1:0] lim_min_s, lim_max_s;
    logic             legal_s, change_s, same_s, run_s, red_entry_s;
    logic             seq_ev_s, exit_short_s, stuck_s, time_ev_s, cycle_ev_s;

    assign legal_s     = is_legal(signal);
    assign change_s    = legal_s && (signal != phase_q);
    assign same_s      = legal_s && (signal == phase_q);
    assign run_s       = (state_q == S_RUN);
    assign red_entry_s = change_s && (signal == RED);

    tsm_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .load1_i (change_s),
        .inc_i   (same_s),
        .count_o (dwell_s)
    );

    // Dwell window of the phase currently being held.
    always_comb begin
        lim_min_s = {CNT_W{1'b0}};
        lim_max_s = {CNT_W{1'b1}};
        case (phase_q)
            RED:     begin lim_min_s = CNT_W'(RED_MIN); lim_max_s = CNT_W'(RED_MAX); end
            YELLOW:  begin lim_min_s = CNT_W'(YEL_MIN); lim_max_s = CNT_W'(YEL_MAX); end
            GREEN:   begin lim_min_s = CNT_W'(GRN_MIN); lim_max_s = CNT_W'(GRN_MAX); end
            default: begin lim_min_s = {CNT_W{1'b0}};   lim_max_s = {CNT_W{1'b1}};   end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: sync on a fresh RED entry, drop sync on any illegal code.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SYNC: begin
                if (red_entry_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_RUN: begin
                if (!legal_s) begin
                    state_d = S_SYNC;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    // Event detection and next values of every registered output.
    always_comb begin
        seq_ev_s     = run_s && change_s && (next_phase(phase_q) != signal);
        exit_short_s = run_s && change_s && (dwell_s < lim_min_s);
        // dwell passes MAX exactly once per phase, so this fires at most once.
        stuck_s      = run_s && same_s && (dwell_s == lim_max_s);
        time_ev_s    = exit_short_s || stuck_s;
        cycle_ev_s   = run_s && red_entry_s && (phase_q == GREEN) &&
                       cycle_ok_q && !exit_short_s;

        phase_d  = change_s ? signal : phase_q;
        synced_d = (state_d == S_RUN);

        if (red_entry_s) begin
            cycle_ok_d = 1'b1;
        end else if (seq_ev_s || time_ev_s) begin
            cycle_ok_d = 1'b0;
        end else begin
            cycle_ok_d = cycle_ok_q;
        end

        cycle_done_d = cycle_ev_s;
        cycle_cnt_d  = cycle_ev_s ? (cycle_cnt_q + 16'd1) : cycle_cnt_q;

`ifdef TSM_STICKY_ERR_EN
        // A new error wins over a coincident clear.
        err_seq_d     = seq_ev_s  || (err_seq_q     && !err_clr);
        err_time_d    = time_ev_s || (err_time_q    && !err_clr);
        err_illegal_d = !legal_s  || (err_illegal_q && !err_clr);
`else
        err_seq_d     = seq_ev_s;
        err_time_d    = time_ev_s;
        err_illegal_d = !legal_s;
`endif
    end

`ifndef TSM_STICKY_ERR_EN
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr;
`endif

    // Output and tracking registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q       <= RED;
            synced_q      <= 1'b0;
            err_seq_q     <= 1'b0;
            err_time_q    <= 1'b0;
            err_illegal_q <= 1'b0;
            cycle_done_q  <= 1'b0;
            cycle_cnt_q   <= 16'd0;
            cycle_ok_q    <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            synced_q      <= synced_d;
            err_seq_q     <= err_seq_d;
            err_time_q    <= err_time_d;
            err_illegal_q <= err_illegal_d;
            cycle_done_q  <= cycle_done_d;
            cycle_cnt_q   <= cycle_cnt_d;
            cycle_ok_q    <= cycle_ok_d;
        end
    end

    assign synced      = synced_q;
    assign phase       = phase_q;
    assign dwell       = dwell_s;
    assign err_seq     = err_seq_q;
    assign err_time    = err_time_q;
    assign err_illegal = err_illegal_q;
    assign cycle_done  = cycle_done_q;
    assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Scoreboard bench for traffic_signal_monitor: the stimulus queues expected
// snapshots tagged with the cycle they must appear in; a monitor on the
// falling edge checks those snapshots and treats any flag or cycle_done seen
// in an untagged cycle as unexpected.
module tb_traffic_signal_monitor;

    localparam logic [2:0] C_RED = 3'b000;
    localparam logic [2:0] C_YEL = 3'b001;
    localparam logic [2:0] C_GRN = 3'b010;
    localparam logic [2:0] C_BAD = 3'b111;

    logic        clk;
    logic        rst;
    logic [2:0]  signal;
    logic        err_clr;
    logic        synced;
    logic [2:0]  phase;
    logic [7:0]  dwell;
    logic        err_seq;
    logic        err_time;
    logic        err_illegal;
    logic        cycle_done;
    logic [15:0] cycle_cnt;

    typedef struct {
        int          at;
        logic        s;
        logic        t;
        logic        i;
        logic        d;
        logic [15:0] cnt;
        logic        sy;
        logic [2:0]  ph;
        logic [7:0]  dw;
    } rec_t;

    rec_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    traffic_signal_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .signal      (signal),
        .err_clr     (err_clr),
        .synced      (synced),
        .phase       (phase),
        .dwell       (dwell),
        .err_seq     (err_seq),
        .err_time    (err_time),
        .err_illegal (err_illegal),
        .cycle_done  (cycle_done),
        .cycle_cnt   (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue an expected snapshot for cycle cyc+ofs.
    task automatic exp(input int ofs, input logic s, input logic t, input logic i,
                       input logic d, input int cnt, input logic sy,
                       input logic [2:0] ph, input int dw);
        rec_t r;
        r.at = cyc + ofs; r.s = s; r.t = t; r.i = i; r.d = d;
        r.cnt = 16'(cnt); r.sy = sy; r.ph = ph; r.dw = 8'(dw);
        q.push_back(r);
    endtask

    // Hold one code on the bus for n sampling edges.
    task automatic drive(input logic [2:0] code, input int n);
        for (int k = 0; k < n; k++) begin
            signal = code;
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare tagged snapshots, reject unexplained events.
    initial begin
        rec_t r;
        logic ev;
        forever begin
            @(negedge clk);
            ev = err_seq | err_time | err_illegal | cycle_done;
            while (q.size() > 0 && q[0].at < cyc) begin
                r = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_snapshot@%0d: not sampled, now cycle %0d", r.at, cyc);
            end
            if (q.size() > 0 && q[0].at == cyc) begin
                r = q.pop_front();
                checks++;
                if ({err_seq, err_time, err_illegal, cycle_done} !== {r.s, r.t, r.i, r.d} ||
                    cycle_cnt !== r.cnt || synced !== r.sy || phase !== r.ph || dwell !== r.dw) begin
                    errors++;
                    $display("FAIL snapshot@%0d: got seq=%b time=%b ill=%b done=%b cnt=%0d sync=%b ph=%b dw=%0d, want seq=%b time=%b ill=%b done=%b cnt=%0d sync=%b ph=%b dw=%0d",
                             cyc, err_seq, err_time, err_illegal, cycle_done, cycle_cnt, synced, phase, dwell,
                             r.s, r.t, r.i, r.d, r.cnt, r.sy, r.ph, r.dw);
                end
            end else begin
                checks++;
                if (ev !== 1'b0) begin
                    errors++;
                    $display("FAIL unexpected_event@%0d: got seq=%b time=%b ill=%b done=%b, want all 0",
                             cyc, err_seq, err_time, err_illegal, cycle_done);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; signal = C_RED; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp(0, 0,0,0,0, 0, 0, C_RED, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: partial first cycle is unjudged, sync on RED entry, one clean cycle.
        drive(C_RED, 22); exp(0, 0,0,0,0, 0, 0, C_RED, 22);
        drive(C_YEL, 6);  exp(0, 0,0,0,0, 0, 0, C_YEL, 6);
        drive(C_GRN, 22); exp(0, 0,0,0,0, 0, 0, C_GRN, 22);
        exp(1, 0,0,0,0, 0, 1, C_RED, 1);
        drive(C_RED, 22); exp(0, 0,0,0,0, 0, 1, C_RED, 22);
        drive(C_YEL, 6);
        drive(C_GRN, 22);
        exp(1, 0,0,0,1, 1, 1, C_RED, 1);
        drive(C_RED, 22);

        // 2: short YELLOW -> err_time at its exit only, spoiled cycle not counted.
        drive(C_YEL, 3);
        exp(1, 0,1,0,0, 1, 1, C_GRN, 1);
        drive(C_GRN, 22);
        exp(1, 0,0,0,0, 1, 1, C_RED, 1);
        drive(C_RED, 22);

        // 3: RED straight to GREEN -> err_seq only.
        exp(1, 1,0,0,0, 1, 1, C_GRN, 1);
        drive(C_GRN, 22);

        // 4: GREEN stuck for 30 -> one err_time when dwell reaches 25, none at exit.
        exp(1, 0,0,0,0, 1, 1, C_RED, 1);
        drive(C_RED, 22);
        drive(C_YEL, 6);
        exp(25, 0,1,0,0, 1, 1, C_GRN, 25);
        drive(C_GRN, 30); exp(0, 0,0,0,0, 1, 1, C_GRN, 30);
        exp(1, 0,0,0,0, 1, 1, C_RED, 1);
        drive(C_RED, 22);

        // 5: illegal code mid-GREEN drops sync and freezes phase/dwell; RED resyncs.
        drive(C_YEL, 6);
        drive(C_GRN, 10);
        exp(1, 0,0,1,0, 1, 0, C_GRN, 10);
        exp(2, 0,0,1,0, 1, 0, C_GRN, 10);
        drive(C_BAD, 2);
        exp(1, 0,0,0,0, 1, 1, C_RED, 1);
        drive(C_RED, 22);
        drive(C_YEL, 6);
        drive(C_GRN, 22);
        exp(1, 0,0,0,1, 2, 1, C_RED, 1);
        // Boundaries: RED at MAX, YELLOW and GREEN at MIN are all clean.
        drive(C_RED, 24); exp(0, 0,0,0,0, 2, 1, C_RED, 24);
        drive(C_YEL, 5);
        drive(C_GRN, 20);
        exp(1, 0,0,0,1, 3, 1, C_RED, 1);
        drive(C_RED, 22);

        // 6: asynchronous reset mid-GREEN clears everything; a fresh sync is needed.
        drive(C_YEL, 6);
        drive(C_GRN, 10); exp(0, 0,0,0,0, 3, 1, C_GRN, 10);
        @(posedge clk); #1;
        rst = 1'b0;
        exp(0, 0,0,0,0, 0, 0, C_RED, 0);
        @(posedge clk); #1;
        exp(0, 0,0,0,0, 0, 0, C_RED, 0);
        signal = C_RED;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(C_RED, 5);  exp(0, 0,0,0,0, 0, 0, C_RED, 5);
        drive(C_YEL, 6);
        drive(C_GRN, 22);
        exp(1, 0,0,0,0, 0, 1, C_RED, 1);
        drive(C_RED, 3);  exp(0, 0,0,0,0, 0, 1, C_RED, 3);

        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_snapshots: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
